// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: two-entry skid buffer with flush.
// Optional HI/LO write-back channel when MEM_WB_HILO_EN is defined.
module mem_wb_pipe #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ZERO_SQUASH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [ADDR_W-1:0] mem_write_addr,
    input  logic              mem_write_en,
`ifdef MEM_WB_HILO_EN
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_whilo,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_write_data,
    output logic [ADDR_W-1:0] wb_write_addr,
    output logic              wb_write_en
);

`ifdef MEM_WB_HILO_EN
    localparam int PW = 3 * DATA_W + ADDR_W + 2;
`else
    localparam int PW = DATA_W + ADDR_W + 1;
`endif

    // State is {skid_valid, main_valid}
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_BUSY  = 2'b01;
    localparam logic [1:0] S_FULL  = 2'b11;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] main_d;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] skid_d;
    logic [PW-1:0] in_pl;
    logic          accept;
    logic          drain;
    logic          main_we;

`ifdef MEM_WB_HILO_EN
    logic main_whilo;
    assign in_pl = {mem_write_data, mem_write_addr, mem_write_en,
                    mem_hi, mem_lo, mem_whilo};
    assign {wb_write_data, wb_write_addr, main_we,
            wb_hi, wb_lo, main_whilo} = main_q;
`else
    assign in_pl = {mem_write_data, mem_write_addr, mem_write_en};
    assign {wb_write_data, wb_write_addr, main_we} = main_q;
`endif

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // State and payload registers; reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and payload moves; flush overrides any handshake
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = in_pl;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (drain && accept) begin
                        main_d = in_pl;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end else if (accept) begin
                        skid_d  = in_pl;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = S_BUSY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Outputs come from main only; enables are gated by its valid bit
    always_comb begin
        out_valid   = state_q[0];
        in_ready    = ~state_q[1];
        wb_write_en = main_we & state_q[0];
        if ((ZERO_SQUASH != 0) && (wb_write_addr == '0)) begin
            wb_write_en = 1'b0;
        end
`ifdef MEM_WB_HILO_EN
        wb_whilo = main_whilo & state_q[0];
`endif
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_mem_wb_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] mem_write_data;
    logic [4:0]  mem_write_addr;
    logic        mem_write_en;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] wb_write_data;
    logic [4:0]  wb_write_addr;
    logic        wb_write_en;
    logic        in_ready_nz;
    logic        out_valid_nz;
    logic [31:0] wb_write_data_nz;
    logic [4:0]  wb_write_addr_nz;
    logic        wb_write_en_nz;
`ifdef MEM_WB_HILO_EN
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic [31:0] wb_hi_nz;
    logic [31:0] wb_lo_nz;
    logic        wb_whilo_nz;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_SQUASH(1)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_write_data (mem_write_data),
        .mem_write_addr (mem_write_addr),
        .mem_write_en   (mem_write_en),
`ifdef MEM_WB_HILO_EN
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_whilo      (mem_whilo),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_whilo       (wb_whilo),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .wb_write_data  (wb_write_data),
        .wb_write_addr  (wb_write_addr),
        .wb_write_en    (wb_write_en)
    );

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_SQUASH(0)) u_nz (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready_nz),
        .mem_write_data (mem_write_data),
        .mem_write_addr (mem_write_addr),
        .mem_write_en   (mem_write_en),
`ifdef MEM_WB_HILO_EN
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_whilo      (mem_whilo),
        .wb_hi          (wb_hi_nz),
        .wb_lo          (wb_lo_nz),
        .wb_whilo       (wb_whilo_nz),
`endif
        .out_valid      (out_valid_nz),
        .out_ready      (out_ready),
        .wb_write_data  (wb_write_data_nz),
        .wb_write_addr  (wb_write_addr_nz),
        .wb_write_en    (wb_write_en_nz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic        ord;
        logic        fl;
        logic [31:0] d;
        logic [4:0]  a;
        logic        we;
        logic        ev;
        logic        er;
        logic [31:0] ed;
        logic [4:0]  ea;
        logic        ewe;
        logic        ewe_nz;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } pl_t;

    vec_t tbl[18];
    pl_t  q[$];
    pl_t  held;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        flush          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        mem_write_data = '0;
        mem_write_addr = '0;
        mem_write_en   = 1'b0;
`ifdef MEM_WB_HILO_EN
        mem_hi    = '0;
        mem_lo    = '0;
        mem_whilo = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_data", wb_write_data, 0);
        check("rst_addr", wb_write_addr, 0);
        check("rst_we", wb_write_en, 0);
`ifdef MEM_WB_HILO_EN
        check("rst_hi", wb_hi, 0);
        check("rst_lo", wb_lo, 0);
        check("rst_whilo", wb_whilo, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input logic iv, input logic ord,
                        input logic [31:0] d, input logic [4:0] a);
        in_valid       = iv;
        out_ready      = ord;
        mem_write_data = d;
        mem_write_addr = a;
        mem_write_en   = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0, 'h11, 1, 1, 1, 1, 'h11, 1, 1, 1};
        tbl[1]  = '{1, 1, 0, 'h22, 2, 1, 1, 1, 'h22, 2, 1, 1};
        tbl[2]  = '{1, 1, 0, 'h33, 3, 1, 1, 1, 'h33, 3, 1, 1};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 1, 'h33, 3, 0, 0};
        tbl[4]  = '{1, 0, 0, 'hA, 4, 1, 1, 1, 'hA, 4, 1, 1};
        tbl[5]  = '{1, 0, 0, 'hB, 5, 1, 1, 0, 'hA, 4, 1, 1};
        tbl[6]  = '{1, 0, 0, 'hC, 6, 1, 1, 0, 'hA, 4, 1, 1};
        tbl[7]  = '{1, 1, 0, 'hC, 6, 1, 1, 1, 'hB, 5, 1, 1};
        tbl[8]  = '{1, 1, 0, 'hC, 6, 1, 1, 1, 'hC, 6, 1, 1};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 1, 'hC, 6, 0, 0};
        tbl[10] = '{1, 0, 0, 'hD1, 7, 1, 1, 1, 'hD1, 7, 1, 1};
        tbl[11] = '{1, 0, 0, 'hD2, 8, 1, 1, 0, 'hD1, 7, 1, 1};
        tbl[12] = '{1, 0, 1, 'hD3, 9, 1, 0, 1, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 'hDEAD, 0, 1, 1, 1, 'hDEAD, 0, 0, 1};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 0, 1, 'hDEAD, 0, 0, 0};
        tbl[16] = '{1, 1, 0, 'h77, 3, 0, 1, 1, 'h77, 3, 0, 0};
        tbl[17] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};

        do_reset();

        for (int i = 0; i < 18; i++) begin
            flush          = tbl[i].fl;
            in_valid       = tbl[i].iv;
            out_ready      = tbl[i].ord;
            mem_write_data = tbl[i].d;
            mem_write_addr = tbl[i].a;
            mem_write_en   = tbl[i].we;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
            check($sformatf("vec%0d_ready", i), in_ready, tbl[i].er);
            check($sformatf("vec%0d_data", i), wb_write_data, tbl[i].ed);
            check($sformatf("vec%0d_addr", i), wb_write_addr, tbl[i].ea);
            check($sformatf("vec%0d_we", i), wb_write_en, tbl[i].ewe);
            check($sformatf("vec%0d_we_nz", i), wb_write_en_nz,
                  tbl[i].ewe_nz);
        end
        idle_inputs();

        // Asynchronous reset while FULL
        send(1, 0, 'h55, 1);
        send(1, 0, 'h66, 2);
        idle_inputs();
        check("full_ready", in_ready, 0);
        check("full_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", wb_write_data, 0);
        check("arst_addr", wb_write_addr, 0);
        check("arst_we", wb_write_en, 0);
        check("arst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("arst_no_ghost", out_valid, 0);
        idle_inputs();

`ifdef MEM_WB_HILO_EN
        in_valid       = 1'b1;
        mem_write_data = 'h1;
        mem_write_addr = 1;
        mem_write_en   = 1'b1;
        mem_hi         = 'h1234;
        mem_lo         = 'h5678;
        mem_whilo      = 1'b1;
        @(negedge clk);
        check("hilo_hi", wb_hi, 'h1234);
        check("hilo_lo", wb_lo, 'h5678);
        check("hilo_whilo", wb_whilo, 1);
        check("hilo_valid", out_valid, 1);
        idle_inputs();
        out_ready = 1'b1;
        @(negedge clk);
        check("hilo_whilo_idle", wb_whilo, 0);
        check("hilo_hi_hold", wb_hi, 'h1234);
        idle_inputs();
`endif

        // Random traffic against the queue model
        do_reset();
        q.delete();
        held = '{default: '0};
        for (int c = 0; c < 400; c++) begin
            logic v;
            logic acc;
            logic drn;
            pl_t  p;
            v = (q.size() > 0);
            check("rnd_valid", out_valid, v);
            check("rnd_ready", in_ready, q.size() < 2);
            check("rnd_data", wb_write_data, held.data);
            check("rnd_addr", wb_write_addr, held.addr);
            check("rnd_we", wb_write_en,
                  held.we && v && (held.addr != 0));
            check("rnd_we_nz", wb_write_en_nz, held.we && v);
`ifdef MEM_WB_HILO_EN
            check("rnd_hi", wb_hi, held.hi);
            check("rnd_lo", wb_lo, held.lo);
            check("rnd_whilo", wb_whilo, held.whilo && v);
`endif
            p.data  = $urandom;
            p.addr  = 5'($urandom_range(0, 31));
            p.we    = 1'($urandom_range(0, 1));
            p.hi    = $urandom;
            p.lo    = $urandom;
            p.whilo = 1'($urandom_range(0, 1));
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            mem_write_data = p.data;
            mem_write_addr = p.addr;
            mem_write_en   = p.we;
`ifdef MEM_WB_HILO_EN
            mem_hi    = p.hi;
            mem_lo    = p.lo;
            mem_whilo = p.whilo;
`endif
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
                held = '{default: '0};
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(p);
                if (q.size() > 0) held = q[0];
            end
            @(negedge clk);
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and an optional HI/LO write-back channel. It sits between the memory stage and the register-file write port. It lets the write-back side back-pressure the pipeline without a combinational ready path. A flush inserts bubbles for exception and branch recovery.

## Interface
- DATA_W, 32, width of write-back data (and HI/LO when enabled)
- ADDR_W, 5, width of register-file address
- ZERO_SQUASH, 1, when 1 a write to address 0 is presented with wb_write_en=0
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous flush; empties both entries
- in_valid  in  1  MEM stage holds a valid result
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- mem_write_data  in  DATA_W  result data
- mem_write_addr  in  ADDR_W  destination register
- mem_write_en  in  1  register-file write request
- mem_hi, mem_lo  in  DATA_W each  HI/LO values (MEM_WB_HILO_EN only)
- mem_whilo  in  1  HI/LO write request (MEM_WB_HILO_EN only)
- out_valid  out  1  main entry valid
- out_ready  in  1  write-back side consumes the main entry this cycle
- wb_write_data  out  DATA_W  main entry data
- wb_write_addr  out  ADDR_W  main entry address
- wb_write_en  out  1  main.we & out_valid & !(ZERO_SQUASH && addr==0)
- wb_hi, wb_lo  out  DATA_W each  main entry HI/LO (MEM_WB_HILO_EN only)
- wb_whilo  out  1  main.whilo & out_valid (MEM_WB_HILO_EN only)

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds a valid bit and a payload {data, addr, we[, hi, lo, whilo]}.
- Handshake definitions:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00)
    - accept: payload loads into main; next state BUSY.
  - BUSY (01)
    - drain & !accept: next state EMPTY.
    - drain & accept: main is replaced by the new payload; stays BUSY.
    - !drain & accept: payload loads into skid; next state FULL.
    - otherwise: hold.
  - FULL (11); in_ready=0, so no accept is possible.
    - drain: skid moves to main, skid is cleared; next state BUSY.
    - otherwise: hold.
- State 10 is unreachable. If it is ever reached, the next edge goes to EMPTY.
- Flush takes priority over every other event.
  - Next edge: both valid bits are 0 and both payloads are zeroed.
  - An accept in the flush cycle is discarded.
  - A drain in the flush cycle still counts as consumed by WB. The block does not itself block that write.
- Outputs are driven only from main. Enable outputs are gated by out_valid, so an invalid entry never writes.
- Data and address outputs hold their last value while out_valid=0; they are zeroed only by reset or flush.
- No arithmetic is performed. Payload widths pass through unchanged.

## Timing
- Reset (rst=0, asynchronous):
  - Both entries are invalid and all payload bits are 0.
  - Outputs: out_valid=0, wb_write_data=0, wb_write_addr=0, wb_write_en=0, wb_hi=wb_lo=0, wb_whilo=0.
  - in_ready=1 from reset release.
- Reset assertion mid-operation drops any pending entries immediately, with no clock needed.
- Latency: an accept at edge N produces out_valid=1 with that payload after edge N.
- Throughput is 1 per cycle while out_ready=1.
- in_ready is a flop output with no combinational path from out_ready.
  - It falls one cycle after the skid entry fills.
  - It rises one cycle after a drain from FULL.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush or reset.

## Configuration
- MEM_WB_HILO_EN defined:
  - The mem_hi/mem_lo/mem_whilo and wb_hi/wb_lo/wb_whilo ports exist.
  - These fields are stored in both entries, follow the same handshake, and are zeroed by flush and reset.
- MEM_WB_HILO_EN undefined:
  - Those ports and storage are absent.
  - All other behaviour is identical.

## Test plan
- Reset then stream: rst=0 → 1; drive data 0x11,0x22,0x33 (addr 1,2,3, we=1, in_valid=1), out_ready=1.
  - Required: out_valid on the next three cycles with wb_write_data=0x11,0x22,0x33 and wb_write_en=1; in_ready stays 1.
- Back-pressure: out_ready=0 while sending 0xA, 0xB.
  - Required: FULL; in_ready=0 the cycle after 0xB is accepted; 0xC is held at the input.
  - Then out_ready=1: outputs are 0xA, 0xB, 0xC in order and in_ready returns to 1.
- Flush in FULL: flush=1 for one cycle with in_valid=1.
  - Required next cycle: out_valid=0, wb_write_en=0, wb_write_data=0, in_ready=1; the flush-cycle input never appears at the output.
- Zero squash: addr=0, we=1, data=0xDEAD, ZERO_SQUASH=1.
  - Required: out_valid=1, wb_write_data=0xDEAD, wb_write_en=0.
  - With ZERO_SQUASH=0: wb_write_en=1.
- Async reset mid-stream: rst=0 between clock edges while FULL.
  - Required: outputs are 0 immediately, before the next edge.
- With MEM_WB_HILO_EN: mem_hi=0x1234, mem_lo=0x5678, whilo=1.
  - Required: wb_hi=0x1234, wb_lo=0x5678, wb_whilo=1 with the same latency as data.
  - wb_whilo=0 whenever out_valid=0.
